// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the programmable-modulus counter family.
//   CNT_UP / CNT_DOWN : encodings of the 'up' direction input
//   terminal_value()  : terminal count for a given direction and modulus.
//                       The function works at TV_W bits, so callers of any
//                       width up to TV_W cast in and out.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int TV_W = 32;

  // Counting up ends at the modulus top value, counting down ends at zero.
  function automatic logic [TV_W-1:0] terminal_value(input logic            up,
                                                     input logic [TV_W-1:0] max_val);
    return (up == CNT_DOWN) ? '0 : max_val;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter
// Up/down counter over 0..max_active with a runtime-programmable modulus.
// A new modulus is staged in a shadow register and is only applied at a
// wrap, so a running count sequence is never cut short.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   en          : count enable (previous stage tc in a cascade)
//   up          : direction, 1 = up, 0 = down
//   load        : parallel load strobe (beats en)
//   load_val    : value to load, clamped to max_active
//   max_wr      : write max_in into the shadow register
//   max_in      : new terminal value (modulus - 1)
//   count       : current count
//   max_active  : modulus top value currently in force
//   max_pending : shadow written but not yet applied
//   tc          : terminal count, combinational
module mod_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int unsigned DEFAULT_MAX = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             max_wr,
  input  logic [WIDTH-1:0] max_in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] max_active,
  output logic             max_pending,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RESET_MAX = WIDTH'(DEFAULT_MAX);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] term;
  logic             at_term;
  logic [WIDTH-1:0] new_max;

  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] max_next;
  logic [WIDTH-1:0] shadow_next;
  logic             pending_next;

  // The terminal value follows the current 'up' input, so a direction change
  // takes effect immediately. count never exceeds max_active, so the count
  // is valid in either direction.
  assign term    = WIDTH'(terminal_value(up, TV_W'(max_active)));
  assign at_term = (count == term);
  assign tc      = en & ~load & ~reset & at_term;

  // Modulus applied at the next wrap.
  assign new_max = max_pending ? shadow : max_active;

  // The shadow write is evaluated last so that a write on a wrap edge
  // re-arms max_pending after the wrap has consumed the old shadow.
  always_comb begin
    count_next   = count;
    max_next     = max_active;
    shadow_next  = shadow;
    pending_next = max_pending;

    if (load) begin
      count_next = (load_val > max_active) ? max_active : load_val;
    end else if (en) begin
      if (at_term) begin
        count_next   = (up == CNT_UP) ? '0 : new_max;
        max_next     = new_max;
        pending_next = 1'b0;
      end else if (up == CNT_UP) begin
        count_next = count + WIDTH'(1);
      end else begin
        count_next = count - WIDTH'(1);
      end
    end

    if (max_wr) begin
      shadow_next  = max_in;
      pending_next = 1'b1;
    end
  end

  // State register; reset also drops any max_wr on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      max_active  <= RESET_MAX;
      shadow      <= RESET_MAX;
      max_pending <= 1'b0;
    end else begin
      count       <= count_next;
      max_active  <= max_next;
      shadow      <= shadow_next;
      max_pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter
// Self-checking bench for mod_counter with WIDTH=4, DEFAULT_MAX=9.
// A behavioural model tracks count, modulus, shadow and pending state as
// plain integers and is advanced once per clock alongside the DUT.
module tb_mod_counter;

  localparam int WIDTH       = 4;
  localparam int DEFAULT_MAX = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             max_wr;
  logic [WIDTH-1:0] max_in;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] max_active;
  logic             max_pending;
  logic             tc;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  int m_count;
  int m_max;
  int m_shadow;
  int m_pending;

  // tc captured just before each clock edge, and the model's expectation
  logic got_tc;
  logic exp_tc;

  mod_counter #(
    .WIDTH      (WIDTH),
    .DEFAULT_MAX(DEFAULT_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .max_wr     (max_wr),
    .max_in     (max_in),
    .count      (count),
    .max_active (max_active),
    .max_pending(max_pending),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  // Terminal count from the rules: enabled, not loading, not in reset,
  // and sitting on the end of the range for the present direction.
  function automatic logic model_tc();
    int t;
    t = up ? m_max : 0;
    return !reset && en && !load && (m_count == t);
  endfunction

  // Advance the model by one clock edge from the current inputs.
  task automatic model_step();
    int nm;
    if (reset) begin
      m_count   = 0;
      m_max     = DEFAULT_MAX;
      m_shadow  = DEFAULT_MAX;
      m_pending = 0;
    end else begin
      nm = m_pending ? m_shadow : m_max;
      if (load) begin
        m_count = (int'(load_val) < m_max) ? int'(load_val) : m_max;
      end else if (en) begin
        if (up && m_count == m_max) begin
          m_count   = 0;
          m_max     = nm;
          m_pending = 0;
        end else if (!up && m_count == 0) begin
          m_count   = nm;
          m_max     = nm;
          m_pending = 0;
        end else begin
          m_count = up ? m_count + 1 : m_count - 1;
        end
      end
      if (max_wr) begin
        m_shadow  = int'(max_in);
        m_pending = 1;
      end
    end
  endtask

  // Sample tc before the edge, clock once, advance model, settle.
  task automatic tick();
    #1;
    got_tc = tc;
    exp_tc = model_tc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset    = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    max_wr   = 1'b0;
    max_in   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count got %0d want 0", count);
    end
    tests_run++;
    if (max_active !== 4'd9 || max_pending !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_max got max=%0d pend=%0b want max=9 pend=0", max_active, max_pending);
    end
    tests_run++;
    if (tc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_tc got %0b want 0", tc);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if (got_tc !== ((i % 10) == 9)) begin
        tests_failed++;
        $display("[TB] FAIL up_tc cycle %0d got %0b want %0b", i, got_tc, (i % 10) == 9);
      end
      tests_run++;
      if (count !== 4'((i + 1) % 10) || max_active !== 4'd9) begin
        tests_failed++;
        $display("[TB] FAIL up_count cycle %0d got %0d/%0d want %0d/9", i, count, max_active, (i + 1) % 10);
      end
    end
  endtask

  task automatic test_shadow();
    do_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    max_wr = 1'b1;
    max_in = 4'd5;
    tick();
    max_wr = 1'b0;
    tests_run++;
    if (max_pending !== 1'b1 || max_active !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL shadow_pending got pend=%0b max=%0d want 1/9", max_pending, max_active);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (count !== 4'(m_count) || got_tc !== exp_tc || max_active !== 4'(m_max)) begin
        tests_failed++;
        $display("[TB] FAIL shadow_seq cycle %0d got c=%0d tc=%0b max=%0d want c=%0d tc=%0b max=%0d",
                 i, count, got_tc, max_active, m_count, exp_tc, m_max);
      end
    end
    tests_run++;
    if (max_active !== 4'd5 || max_pending !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL shadow_applied got max=%0d pend=%0b want 5/0", max_active, max_pending);
    end
  endtask

  task automatic test_count_down();
    do_reset();
    en = 1'b1;
    up = 1'b0;
    tick();
    tests_run++;
    if (got_tc !== 1'b1 || count !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL down_first got tc=%0b c=%0d want 1/9", got_tc, count);
    end
    for (int i = 0; i < 14; i++) begin
      max_wr = (i == 4);
      max_in = 4'd12;
      tick();
      tests_run++;
      if (count !== 4'(m_count) || got_tc !== exp_tc || max_active !== 4'(m_max)
          || max_pending !== m_pending[0]) begin
        tests_failed++;
        $display("[TB] FAIL down_seq cycle %0d got c=%0d tc=%0b max=%0d want c=%0d tc=%0b max=%0d",
                 i, count, got_tc, max_active, m_count, exp_tc, m_max);
      end
    end
    max_wr = 1'b0;
    tests_run++;
    if (max_active !== 4'd12 || count !== 4'd8) begin
      tests_failed++;
      $display("[TB] FAIL down_reload got max=%0d c=%0d want 12/8", max_active, count);
    end
  endtask

  task automatic test_load();
    do_reset();
    load     = 1'b1;
    load_val = 4'd14;
    tick();
    load = 1'b0;
    tests_run++;
    if (count !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL load_clamp got %0d want 9", count);
    end
    max_wr = 1'b1;
    max_in = 4'd3;
    tick();
    max_wr   = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b1;
    load_val = 4'd2;
    tick();
    load = 1'b0;
    tests_run++;
    if (got_tc !== 1'b0 || count !== 4'd2 || max_pending !== 1'b1 || max_active !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL load_vs_wrap got tc=%0b c=%0d pend=%0b max=%0d want 0/2/1/9",
               got_tc, count, max_pending, max_active);
    end
  endtask

  task automatic test_max_extremes();
    do_reset();
    en     = 1'b1;
    up     = 1'b1;
    max_wr = 1'b1;
    max_in = 4'd0;
    tick();
    max_wr = 1'b0;
    for (int i = 0; i < 20 && m_max != 0; i++) tick();
    tests_run++;
    if (max_active !== 4'd0 || count !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL max0_apply got max=%0d c=%0d want 0/0", max_active, count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (got_tc !== 1'b1 || count !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL max0_hold cycle %0d got tc=%0b c=%0d want 1/0", i, got_tc, count);
      end
    end
    max_wr = 1'b1;
    max_in = 4'd15;
    tick();
    max_wr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      tests_run++;
      if (count !== 4'(m_count) || got_tc !== exp_tc || max_active !== 4'(m_max)) begin
        tests_failed++;
        $display("[TB] FAIL max15_seq cycle %0d got c=%0d tc=%0b max=%0d want c=%0d tc=%0b max=%0d",
                 i, count, got_tc, max_active, m_count, exp_tc, m_max);
      end
    end
  endtask

  task automatic test_reset_mid_and_hold();
    do_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      max_wr = (i == 2);
      max_in = 4'd4;
      tick();
    end
    max_wr = 1'b0;
    tests_run++;
    if (count !== 4'd7 || max_pending !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset got c=%0d pend=%0b want 7/1", count, max_pending);
    end
    reset  = 1'b1;
    max_wr = 1'b1;
    max_in = 4'd2;
    tick();
    reset  = 1'b0;
    max_wr = 1'b0;
    tests_run++;
    if (count !== 4'd0 || max_active !== 4'd9 || max_pending !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset got c=%0d max=%0d pend=%0b want 0/9/0", count, max_active, max_pending);
    end
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (count !== 4'd3 || got_tc !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold cycle %0d got c=%0d tc=%0b want 3/0", i, count, got_tc);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom);
      max_wr   = ($urandom_range(0, 11) == 0);
      max_in   = 4'($urandom);
      tick();
      tests_run++;
      if (count !== 4'(m_count) || max_active !== 4'(m_max) || max_pending !== m_pending[0]
          || got_tc !== exp_tc) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d got c=%0d max=%0d pend=%0b tc=%0b want c=%0d max=%0d pend=%0d tc=%0b",
                 i, count, max_active, max_pending, got_tc, m_count, m_max, m_pending, exp_tc);
      end
    end
  endtask

  initial begin
    m_count   = 0;
    m_max     = DEFAULT_MAX;
    m_shadow  = DEFAULT_MAX;
    m_pending = 0;
    idle_inputs();
    test_reset();
    test_count_up();
    test_shadow();
    test_count_down();
    test_load();
    test_max_extremes();
    test_reset_mid_and_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
